vx_index_release: RTL
=====================

VX_INDEX_RELEASE -- requirements
Module: vx_index_release

Interface
REQ-001 SHALL have parameter DATAW, default 1, width of the per-slot metadata read back from the index buffer.
REQ-002 SHALL have parameter RSPW, default 1, width of the response payload.
REQ-003 SHALL have parameter SIZE, default 1, number of slots (tags).
REQ-004 SHALL have parameter MAXBEATS, default 1, maximum number of beats per tag.
REQ-005 SHALL have derived parameters ADDRW = LOG2UP(SIZE) and BEATW = LOG2UP(MAXBEATS).
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port reset_n, input, 1, reset; reset is synchronous and active-low.
REQ-008 SHALL have port rsp_valid, input, 1, response beat valid.
REQ-009 SHALL have port rsp_tag, input, ADDRW, slot index of the response beat.
REQ-010 SHALL have port rsp_data, input, RSPW, response payload.
REQ-011 SHALL have port rsp_last, input, 1, final beat for this tag.
REQ-012 SHALL have port rsp_ready, output, 1, response beat accepted when high together with rsp_valid.
REQ-013 SHALL have port read_addr, output, ADDRW, metadata lookup address.
REQ-014 SHALL have port read_data, input, DATAW, metadata for the read_addr presented in the previous cycle.
REQ-015 SHALL have port release_addr, output, ADDRW, slot to free.
REQ-016 SHALL have port release_slot, output, 1, one-cycle slot-free strobe.
REQ-017 SHALL have port out_valid, output, 1, merged beat valid.
REQ-018 SHALL have port out_tag, output, ADDRW, tag of the merged beat.
REQ-019 SHALL have port out_meta, output, DATAW, metadata of the merged beat.
REQ-020 SHALL have port out_data, output, RSPW, payload of the merged beat.
REQ-021 SHALL have port out_beat, output, BEATW, beat index within the tag.
REQ-022 SHALL have port out_last, output, 1, final beat of the tag.
REQ-023 SHALL have port out_ready, input, 1, downstream ready.
REQ-024 SHALL have port busy, output, 1, any pipeline stage holds a beat.
REQ-025 SHALL have port err, output, 1, sticky beat-overflow error.

Function
REQ-026 The block SHALL use a two-stage pipeline: stage L (lookup register: tag, data, last, beat, valid) and stage O (output register feeding the out_* ports).
REQ-027 A response beat SHALL be accepted on rsp_valid && rsp_ready and captured into stage L on that clock edge.
REQ-028 rsp_ready SHALL equal !L_valid || L_advance, where L_advance = L_valid && (!out_valid || out_ready).
REQ-029 read_addr SHALL be rsp_tag in a cycle where a beat is accepted, otherwise L_tag, so that read_data always matches L_tag while L_valid holds.
REQ-030 On L_advance, stage O SHALL capture L_tag, read_data, L_data, L_beat and L_last, and set out_valid.
REQ-031 out_valid SHALL clear on out_valid && out_ready && !L_advance; stage O contents SHALL remain stable while out_valid && !out_ready.
REQ-032 Latency SHALL be 2 cycles from beat acceptance to out_valid when there is no backpressure; sustained throughput SHALL be 1 beat per cycle.
REQ-033 The block SHALL keep a per-tag beat counter array of SIZE x BEATW bits; on acceptance L_beat SHALL equal the counter for rsp_tag, and the counter SHALL be incremented, or cleared to 0 if rsp_last.
REQ-034 If a beat is accepted with its counter equal to MAXBEATS-1 and rsp_last=0, err SHALL set and remain set until reset, and the counter SHALL wrap to 0.
REQ-035 release_slot SHALL be asserted combinationally, and release_addr SHALL equal out_tag, exactly in cycles where out_valid && out_ready && out_last; release_addr SHALL be 0 otherwise.
REQ-036 Each tag SHALL be released exactly once per last beat, and a non-last beat SHALL never assert release_slot.
REQ-037 Beats SHALL be emitted in acceptance order, whatever their tags.
REQ-038 busy SHALL equal L_valid || out_valid.

Reset
REQ-039 While reset_n=0 at a clock edge, L_valid, out_valid, err and all beat counters SHALL be cleared; rsp_ready SHALL be 1 and release_slot SHALL be 0 in the cycle after reset.
REQ-040 A reset asserted mid-operation SHALL discard in-flight beats without asserting release_slot for them.
REQ-041 The datapath registers (tag, data, meta) SHALL NOT require reset values.

Verification
REQ-042 Single beat: tag=3, last=1, read_data=0xAB, out_ready=1 -> out_valid 2 cycles later with out_tag=3, out_meta=0xAB, out_beat=0, and release_slot=1 with release_addr=3 in that same cycle.
REQ-043 Multi-beat: MAXBEATS=4, tag 5 sends 3 beats (last on the third) -> out_beat 0,1,2, and exactly one release_slot, on the third beat.
REQ-044 Backpressure: out_ready=0 for 5 cycles during back-to-back beats -> rsp_ready drops after 2 accepted beats, out_* stays stable, and no beat is lost or duplicated after out_ready=1.
REQ-045 Interleaved tags 1,2,1(last),2(last) with read_data changing per address -> out_meta matches each tag, and releases occur for 1 then 2.
REQ-046 Overflow: MAXBEATS=2, tag 0 sends 3 non-last beats -> err=1 from the cycle after the second beat and stays set until reset_n=0.
REQ-047 Reset asserted with both stages full -> busy=0, out_valid=0 and rsp_ready=1 after one edge, with no release_slot pulse.

Source files
------------

// File: rtl/vx_index_release.sv
// Response-release stage: tags each beat with its per-tag beat index, looks up slot metadata,
// and frees the slot when the final beat of a tag leaves the block.
module vx_index_release #(
  parameter int unsigned DATAW    = 1,
  parameter int unsigned RSPW     = 1,
  parameter int unsigned SIZE     = 1,
  parameter int unsigned MAXBEATS = 1,
  localparam int unsigned ADDRW   = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int unsigned BEATW   = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rsp_valid,
  input  logic [ADDRW-1:0] rsp_tag,
  input  logic [RSPW-1:0]  rsp_data,
  input  logic             rsp_last,
  output logic             rsp_ready,
  output logic [ADDRW-1:0] read_addr,
  input  logic [DATAW-1:0] read_data,
  output logic [ADDRW-1:0] release_addr,
  output logic             release_slot,
  output logic             out_valid,
  output logic [ADDRW-1:0] out_tag,
  output logic [DATAW-1:0] out_meta,
  output logic [RSPW-1:0]  out_data,
  output logic [BEATW-1:0] out_beat,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  logic             l_valid;
  logic [ADDRW-1:0] l_tag;
  logic [RSPW-1:0]  l_data;
  logic [BEATW-1:0] l_beat;
  logic             l_last;

  logic [BEATW-1:0] beat_cnt [SIZE];

  logic             l_advance;
  logic             accept;
  logic [BEATW-1:0] cur_cnt;
  logic             cnt_wrap;

  always_comb begin
    l_advance    = l_valid && (!out_valid || out_ready);
    rsp_ready    = !l_valid || l_advance;
    accept       = rsp_valid && rsp_ready;
    // Look up the incoming tag so read_data lines up with stage L on the next cycle.
    read_addr    = accept ? rsp_tag : l_tag;
    cur_cnt      = beat_cnt[rsp_tag];
    cnt_wrap     = (cur_cnt == BEATW'(MAXBEATS - 1));
    release_slot = out_valid && out_ready && out_last;
    release_addr = release_slot ? out_tag : '0;
    busy         = l_valid || out_valid;
  end

  // Control state and beat counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      l_valid   <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < int'(SIZE); i++) begin
        beat_cnt[i] <= '0;
      end
    end else begin
      if (accept) begin
        l_valid <= 1'b1;
      end else if (l_advance) begin
        l_valid <= 1'b0;
      end

      if (l_advance) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (rsp_last || cnt_wrap) begin
          beat_cnt[rsp_tag] <= '0;
        end else begin
          beat_cnt[rsp_tag] <= cur_cnt + 1'b1;
        end
        if (cnt_wrap && !rsp_last) begin
          err <= 1'b1;
        end
      end
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      l_tag  <= rsp_tag;
      l_data <= rsp_data;
      l_last <= rsp_last;
      l_beat <= cur_cnt;
    end
    if (l_advance) begin
      out_tag  <= l_tag;
      out_meta <= read_data;
      out_data <= l_data;
      out_beat <= l_beat;
      out_last <= l_last;
    end
  end

endmodule
